// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and default divider.
// Used by both the transmit and receive paths.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 3'd0;
  localparam uart_state_t ST_START = 3'd1;
  localparam uart_state_t ST_DATA  = 3'd2;
  localparam uart_state_t ST_PAR   = 3'd3;
  localparam uart_state_t ST_STOP  = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // 50 MHz system clock at 115200 baud
  localparam int CLK_DIV_DEFAULT = 434;

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: load sets the period, tick fires while enabled at zero.
// Holds its value when disabled so it stays quiet in idle.
module uart_baud_tick #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding register so the next byte can be
// buffered while the current frame is on the line.
//
// state | meaning
// IDLE  | line high, waiting for a held byte
// START | start bit (low)
// DATA  | 8 data bits, LSB first
// PAR   | parity bit (only when PARITY != none)
// STOP  | STOP_BITS stop bits (high)
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEFAULT,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [2:0]  LAST_STOP   = 3'(STOP_BITS - 1);

  uart_state_t state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        par_q, par_d;
  logic        txd_q, txd_d;
  logic        baud_load;
  logic        baud_tick;

  uart_baud_tick #(.W(16)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .load     (baud_load),
    .en       (state_q != ST_IDLE),
    .load_val (BAUD_RELOAD),
    .tick     (baud_tick)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_d       = par_q;
    txd_d       = txd_q;
    baud_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          state_d     = ST_START;
          shift_d     = hold_q;
          par_d       = parity_bit(hold_q, PARITY);
          hold_full_d = 1'b0;
          txd_d       = 1'b0;
          baud_load   = 1'b1;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
          txd_d     = shift_q[0];
          baud_load = 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          baud_load = 1'b1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PAR;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      ST_PAR: begin
        if (baud_tick) begin
          state_d   = ST_STOP;
          bit_cnt_d = 3'd0;
          txd_d     = 1'b1;
          baud_load = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (bit_cnt_q != LAST_STOP) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            baud_load = 1'b1;
          end else if (hold_full_q) begin
            // back-to-back frame: no idle gap on the line
            state_d     = ST_START;
            shift_d     = hold_q;
            par_d       = parity_bit(hold_q, PARITY);
            hold_full_d = 1'b0;
            bit_cnt_d   = 3'd0;
            txd_d       = 1'b0;
            baud_load   = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            txd_d     = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // accept only when empty, so it never collides with the clear above
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      par_q       <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      txd_q       <= txd_d;
    end
  end

  assign tx_ready = !hold_full_q;
  assign tx_busy  = (state_q != ST_IDLE) || hold_full_q;
  assign txd      = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLK_DIV=4 across parity and stop-bit variants.
// Instance 0: no parity/1 stop, 1: even, 2: odd, 3: no parity/2 stop.
module tb_uart_tx;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic [3:0] tx_valid;
  logic [3:0] tx_ready;
  logic [3:0] txd;
  logic [3:0] tx_busy;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLK_DIV(4), .PARITY(PARITY_NONE), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .txd(txd[0]), .tx_busy(tx_busy[0]));
  uart_tx #(.CLK_DIV(4), .PARITY(PARITY_EVEN), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .txd(txd[1]), .tx_busy(tx_busy[1]));
  uart_tx #(.CLK_DIV(4), .PARITY(PARITY_ODD), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .txd(txd[2]), .tx_busy(tx_busy[2]));
  uart_tx #(.CLK_DIV(4), .PARITY(PARITY_NONE), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .txd(txd[3]), .tx_busy(tx_busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one-cycle valid pulse; returns 1 time unit after the accepting edge
  task automatic send(input int inst, input logic [7:0] d);
    tx_data = d;
    tx_valid[inst] = 1'b1;
    cyc(1);
    tx_valid[inst] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tx_valid = 4'b0000;
    tx_data = 8'h00;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (txd[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_txd inst=%0d got=%b exp=1", i, txd[i]);
      end
      checks++;
      if (tx_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready inst=%0d got=%b exp=1", i, tx_ready[i]);
      end
      checks++;
      if (tx_busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy inst=%0d got=%b exp=0", i, tx_busy[i]);
      end
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    tx_data = 8'h3C;
    tx_valid[0] = 1'b1;
    cyc(1);
    tx_valid[0] = 1'b0;
    checks++;
    if (tx_ready[0] !== 1'b0 || tx_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL first_accept ready=%b busy=%b exp ready=0 busy=1", tx_ready[0], tx_busy[0]);
    end
    cyc(45);
    checks++;
    if (tx_busy[0] !== 1'b0 || txd[0] !== 1'b1) begin
      errors++;
      $display("FAIL first_frame_done busy=%b txd=%b exp busy=0 txd=1", tx_busy[0], txd[0]);
    end
  endtask

  task automatic test_basic;
    logic [9:0] f;
    f = {1'b1, 8'h55, 1'b0};
    send(0, 8'h55);
    checks++;
    if (txd[0] !== 1'b1 || tx_ready[0] !== 1'b0 || tx_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL hold_cycle txd=%b ready=%b busy=%b exp 1 0 1", txd[0], tx_ready[0], tx_busy[0]);
    end
    cyc(1);
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (txd[0] !== f[k/4]) begin
        errors++;
        $display("FAIL basic_55 sample=%0d got=%b exp=%b", k, txd[0], f[k/4]);
      end
      cyc(1);
    end
    checks++;
    if (tx_busy[0] !== 1'b0 || txd[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_done busy=%b txd=%b exp busy=0 txd=1", tx_busy[0], txd[0]);
    end
  endtask

  task automatic test_parity;
    logic [10:0] fe;
    logic [10:0] fo;
    fe = {1'b1, 1'b0, 8'hA5, 1'b0};
    fo = {1'b1, 1'b1, 8'hA5, 1'b0};
    tx_data = 8'hA5;
    tx_valid[1] = 1'b1;
    tx_valid[2] = 1'b1;
    cyc(1);
    tx_valid[1] = 1'b0;
    tx_valid[2] = 1'b0;
    cyc(1);
    for (int k = 0; k < 44; k++) begin
      checks++;
      if (txd[1] !== fe[k/4]) begin
        errors++;
        $display("FAIL parity_even sample=%0d got=%b exp=%b", k, txd[1], fe[k/4]);
      end
      checks++;
      if (txd[2] !== fo[k/4]) begin
        errors++;
        $display("FAIL parity_odd sample=%0d got=%b exp=%b", k, txd[2], fo[k/4]);
      end
      cyc(1);
    end
    checks++;
    if (tx_busy[1] !== 1'b0 || tx_busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL parity_done busy_even=%b busy_odd=%b exp 0 0", tx_busy[1], tx_busy[2]);
    end
  endtask

  task automatic test_two_stop;
    send(3, 8'hFF);
    cyc(1);
    for (int k = 0; k < 44; k++) begin
      checks++;
      if (txd[3] !== (k >= 4)) begin
        errors++;
        $display("FAIL two_stop sample=%0d got=%b exp=%b", k, txd[3], (k >= 4));
      end
      cyc(1);
    end
    checks++;
    if (tx_busy[3] !== 1'b0) begin
      errors++;
      $display("FAIL two_stop_done busy=%b exp=0", tx_busy[3]);
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] bb;
    bb = {1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0};
    tx_data = 8'h01;
    tx_valid[0] = 1'b1;
    cyc(1);
    checks++;
    if (tx_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_held ready=%b exp=0", tx_ready[0]);
    end
    tx_data = 8'h02;
    cyc(1);
    for (int k = 0; k < 80; k++) begin
      if (k == 1) begin
        checks++;
        if (tx_ready[0] !== 1'b0 || tx_busy[0] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_second_accept ready=%b busy=%b exp 0 1", tx_ready[0], tx_busy[0]);
        end
        tx_valid[0] = 1'b0;
      end
      checks++;
      if (txd[0] !== bb[k/4]) begin
        errors++;
        $display("FAIL b2b sample=%0d got=%b exp=%b", k, txd[0], bb[k/4]);
      end
      cyc(1);
    end
    checks++;
    if (tx_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done busy=%b exp=0", tx_busy[0]);
    end
  endtask

  task automatic test_accept_at_stop_end;
    send(0, 8'h00);
    cyc(40);
    tx_data = 8'h81;
    tx_valid[0] = 1'b1;
    cyc(1);
    tx_valid[0] = 1'b0;
    checks++;
    if (txd[0] !== 1'b1 || tx_busy[0] !== 1'b1 || tx_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL stop_accept_idle txd=%b busy=%b ready=%b exp 1 1 0", txd[0], tx_busy[0], tx_ready[0]);
    end
    cyc(1);
    checks++;
    if (txd[0] !== 1'b0) begin
      errors++;
      $display("FAIL stop_accept_start txd=%b exp=0", txd[0]);
    end
    cyc(4);
    checks++;
    if (txd[0] !== 1'b1) begin
      errors++;
      $display("FAIL stop_accept_bit0 txd=%b exp=1", txd[0]);
    end
    cyc(40);
    checks++;
    if (tx_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL stop_accept_done busy=%b exp=0", tx_busy[0]);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic seen_low;
    send(0, 8'h00);
    cyc(1);
    tx_data = 8'hAA;
    tx_valid[0] = 1'b1;
    cyc(1);
    tx_valid[0] = 1'b0;
    checks++;
    if (tx_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_held ready=%b exp=0", tx_ready[0]);
    end
    cyc(16);
    checks++;
    if (txd[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_bit3 txd=%b exp=0", txd[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (txd[0] !== 1'b1 || tx_ready[0] !== 1'b1 || tx_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async txd=%b ready=%b busy=%b exp 1 1 0", txd[0], tx_ready[0], tx_busy[0]);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    seen_low = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (txd[0] !== 1'b1) seen_low = 1'b1;
      cyc(1);
    end
    checks++;
    if (seen_low !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_frame seen_low=%b exp=0", seen_low);
    end
    checks++;
    if (tx_ready[0] !== 1'b1 || tx_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_after ready=%b busy=%b exp 1 0", tx_ready[0], tx_busy[0]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_two_stop;
    test_back_to_back;
    test_accept_at_stop_end;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 434, meaning clock cycles per bit period (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter PARITY, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-003 Parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 and 2.
REQ-004 Port clk, input, 1, meaning sole clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1, meaning asynchronous active-high reset.
REQ-006 Port tx_data, input, 8, meaning byte to send, sampled on accept.
REQ-007 Port tx_valid, input, 1, meaning tx_data is valid.
REQ-008 Port tx_ready, output, 1, meaning the holding register can accept a byte.
REQ-009 Port txd, output, 1, meaning serial line, idle high, driven directly from a flop.
REQ-010 Port tx_busy, output, 1, meaning a frame is on the line or a byte is held.

Function
REQ-011 Accept SHALL occur on a cycle with tx_valid=1 and tx_ready=1; tx_data SHALL be loaded into a one-entry holding register.
REQ-012 tx_ready SHALL equal NOT holding_full; it SHALL NOT depend combinationally on tx_valid.
REQ-013 FSM states SHALL be IDLE, START, DATA, PAR, STOP.
REQ-014 IDLE->START when holding_full; the byte SHALL move to the shift register and holding_full SHALL clear in the same cycle.
REQ-015 A byte accepted while IDLE with holding empty SHALL drive txd low on accept cycle +2 (one cycle to hold, one cycle to load).
REQ-016 START: txd=0 for CLK_DIV cycles, then DATA.
REQ-017 DATA: 8 bits LSB first, each held CLK_DIV cycles; bit counter 0..7; after bit 7 go to PAR if PARITY!=0, else STOP.
REQ-018 PAR: txd = XOR of the 8 data bits for even parity, its inverse for odd parity, held CLK_DIV cycles.
REQ-019 STOP: txd=1 for STOP_BITS*CLK_DIV cycles.
REQ-020 At the end of STOP: if holding_full, go to START with no idle gap (back-to-back frames); else go to IDLE.
REQ-021 A new byte SHALL be acceptable from the cycle after START is entered, so the next frame is buffered during the current frame.
REQ-022 The baud counter SHALL load CLK_DIV-1 on each bit start and decrement to 0; bit advance SHALL occur at 0; the counter SHALL NOT run in IDLE.
REQ-023 tx_busy SHALL equal (state!=IDLE) OR holding_full.
REQ-024 On simultaneous accept and end of STOP with holding previously empty, the next frame SHALL start one cycle later via IDLE->START.
REQ-025 Changes to tx_data or tx_valid while tx_ready=0 SHALL have no effect.

Reset
REQ-026 While rst=1: txd=1, tx_ready=1, tx_busy=0, state=IDLE, holding_full=0, counters=0, asynchronously.
REQ-027 Reset mid-frame SHALL abort the frame, drive txd high immediately and discard the held byte.
REQ-028 Release of rst SHALL be usable synchronously; the first accept is allowed on the first clk edge after release.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state type, the PARITY encodings (NONE/EVEN/ODD) and the default CLK_DIV constant, shared with the RX path.
REQ-030 Sub-module uart_baud_tick (down-counter with load/enable and a tick output) SHALL be instantiated and SHALL be reusable by the receiver.
REQ-031 The implementation SHALL total 120-400 lines of RTL with no inferred latches.

Verification (CLK_DIV=4)
REQ-032 Send 0x55 with PARITY=0, STOP_BITS=1 -> txd = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total, then tx_busy=0.
REQ-033 Send 0xA5 with PARITY=1 -> parity bit = 0; with PARITY=2 -> parity bit = 1; frame length 44 cycles.
REQ-034 Hold tx_valid high with 0x01 then 0x02 -> the second byte is accepted during frame 1, and its start bit directly follows the stop bit of frame 1 with no high gap.
REQ-035 STOP_BITS=2 with byte 0xFF -> txd low 4 cycles, then high 40 cycles.
REQ-036 Assert rst during bit 3 with a byte held -> txd=1 the same cycle; after release no frame is sent, tx_ready=1 and tx_busy=0.
